// File: rtl/seq_checker.sv
// Phase-locking checker for the 8-step JK counter cycle 7,13,7,9,6,12,2,8.
// Acquires on a unique value, locks after LOCK_COUNT matches, flags and counts deviations.
module seq_checker #(
    parameter int LOCK_COUNT = 3,
    parameter int ERR_W      = 8
) (
    input  logic             C,
    input  logic             R,
    input  logic             en,
    input  logic [3:0]       Q,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] period_count,
    output logic             period_done,
    output logic [2:0]       pos,
    output logic [3:0]       expected
);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    localparam logic [2:0] LOCK_N = 3'(LOCK_COUNT);

    state_t           state, state_n;
    logic [2:0]       mcnt, mcnt_n, pos_n, pos_inc, mcnt_inc;
    logic             err_n, pd_n, match;
    logic [ERR_W-1:0] ec_n, pc_n;
    logic [3:0]       uniq;

    function automatic logic [3:0] rom(input logic [2:0] i);
        case (i)
            3'd0:    rom = 4'd7;
            3'd1:    rom = 4'd13;
            3'd2:    rom = 4'd7;
            3'd3:    rom = 4'd9;
            3'd4:    rom = 4'd6;
            3'd5:    rom = 4'd12;
            3'd6:    rom = 4'd2;
            default: rom = 4'd8;
        endcase
    endfunction

    // {hit, idx}: 7 is ambiguous and never used to acquire
    function automatic logic [3:0] lookup(input logic [3:0] v);
        case (v)
            4'd13:   lookup = {1'b1, 3'd1};
            4'd9:    lookup = {1'b1, 3'd3};
            4'd6:    lookup = {1'b1, 3'd4};
            4'd12:   lookup = {1'b1, 3'd5};
            4'd2:    lookup = {1'b1, 3'd6};
            4'd8:    lookup = {1'b1, 3'd7};
            default: lookup = 4'd0;
        endcase
    endfunction

    always_ff @(posedge C) begin
        if (R) begin
            state        <= SEARCH;
            pos          <= '0;
            mcnt         <= '0;
            err          <= 1'b0;
            period_done  <= 1'b0;
            err_count    <= '0;
            period_count <= '0;
        end else begin
            state        <= state_n;
            pos          <= pos_n;
            mcnt         <= mcnt_n;
            err          <= err_n;
            period_done  <= pd_n;
            err_count    <= ec_n;
            period_count <= pc_n;
        end
    end

    assign uniq     = lookup(Q);
    assign pos_inc  = pos + 3'd1;
    assign mcnt_inc = mcnt + 3'd1;
    assign match    = (Q == expected);

    always_comb begin
        state_n = state;
        pos_n   = pos;
        mcnt_n  = mcnt;
        err_n   = 1'b0;
        pd_n    = 1'b0;
        ec_n    = err_count;
        pc_n    = period_count;
        if (en) begin
            case (state)
                SEARCH: begin
                    if (uniq[3]) begin
                        state_n = ACQUIRE;
                        pos_n   = uniq[2:0];
                        mcnt_n  = '0;
                    end
                end
                ACQUIRE: begin
                    if (match) begin
                        pos_n  = pos_inc;
                        mcnt_n = mcnt_inc;
                        if (mcnt_inc == LOCK_N) begin
                            state_n = LOCKED;
                            mcnt_n  = '0;
                        end
                    end else begin
                        state_n = SEARCH;
                        pos_n   = '0;
                        mcnt_n  = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        pos_n = pos_inc;
                        if (pos_inc == 3'd7) begin
                            pd_n = 1'b1;
                            pc_n = period_count + ERR_W'(1);
                        end
                    end else begin
                        err_n   = 1'b1;
                        state_n = SEARCH;
                        pos_n   = '0;
                        mcnt_n  = '0;
                        if (~&err_count) ec_n = err_count + ERR_W'(1);
                    end
                end
                default: begin
                    state_n = SEARCH;
                    pos_n   = '0;
                    mcnt_n  = '0;
                end
            endcase
        end
    end

    always_comb begin
        locked   = (state == LOCKED);
        expected = (state == SEARCH) ? 4'd0 : rom(pos_inc);
    end

endmodule

// File: tb/tb_seq_checker.sv
// Table-driven bench for seq_checker; a second instance with ERR_W=2 shares the stimulus
// to exercise err_count saturation.
module tb_seq_checker;

    logic       C = 1'b0;
    logic       R = 1'b1;
    logic       en = 1'b0;
    logic [3:0] Q = 4'd0;

    logic       locked, err, period_done;
    logic [7:0] err_count, period_count;
    logic [2:0] pos;
    logic [3:0] expected;

    logic       locked2, err2, period_done2;
    logic [1:0] err_count2, period_count2;
    logic [2:0] pos2;
    logic [3:0] expected2;

    seq_checker #(.LOCK_COUNT(3), .ERR_W(8)) dut (
        .C(C), .R(R), .en(en), .Q(Q),
        .locked(locked), .err(err), .err_count(err_count), .period_count(period_count),
        .period_done(period_done), .pos(pos), .expected(expected)
    );

    seq_checker #(.LOCK_COUNT(3), .ERR_W(2)) dut2 (
        .C(C), .R(R), .en(en), .Q(Q),
        .locked(locked2), .err(err2), .err_count(err_count2), .period_count(period_count2),
        .period_done(period_done2), .pos(pos2), .expected(expected2)
    );

    always #5 C = ~C;

    typedef struct {
        logic       r, e;
        logic [3:0] q;
        logic       lk, er, pd;
        logic [2:0] pos;
        logic [3:0] ex;
        int         ec, pc;
    } vec_t;

    vec_t vecs[$];
    vec_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic e, input int q, input logic lk, input logic er,
                       input logic pd, input int p, input int ex, input int ec, input int pc);
        vec_t v;
        v.r = r; v.e = e; v.q = 4'(q); v.lk = lk; v.er = er; v.pd = pd;
        v.pos = 3'(p); v.ex = 4'(ex); v.ec = ec; v.pc = pc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s vec %0d: got %0d, want %0d", name, idx, act, req);
        end
    endtask

    initial begin
        vec_t v;
        //   r  e  q   lk er pd pos ex  ec pc
        add(1, 1, 0,  0, 0, 0, 0, 0,  0, 0);
        add(0, 1, 7,  0, 0, 0, 0, 0,  0, 0);
        add(0, 1, 13, 0, 0, 0, 1, 7,  0, 0);
        add(0, 1, 7,  0, 0, 0, 2, 9,  0, 0);
        add(0, 1, 9,  0, 0, 0, 3, 6,  0, 0);
        add(0, 1, 6,  1, 0, 0, 4, 12, 0, 0);
        add(0, 1, 12, 1, 0, 0, 5, 2,  0, 0);
        add(0, 1, 2,  1, 0, 0, 6, 8,  0, 0);
        add(0, 1, 8,  1, 0, 1, 7, 7,  0, 1);
        add(0, 1, 7,  1, 0, 0, 0, 13, 0, 1);
        add(0, 1, 13, 1, 0, 0, 1, 7,  0, 1);
        add(0, 1, 7,  1, 0, 0, 2, 9,  0, 1);
        add(0, 1, 9,  1, 0, 0, 3, 6,  0, 1);
        add(0, 1, 6,  1, 0, 0, 4, 12, 0, 1);
        add(0, 1, 5,  0, 1, 0, 0, 0,  1, 1);
        add(0, 1, 2,  0, 0, 0, 6, 8,  1, 1);
        add(0, 1, 8,  0, 0, 0, 7, 7,  1, 1);
        add(0, 1, 7,  0, 0, 0, 0, 13, 1, 1);
        add(0, 1, 13, 1, 0, 0, 1, 7,  1, 1);
        add(0, 1, 7,  1, 0, 0, 2, 9,  1, 1);
        add(0, 0, 3,  1, 0, 0, 2, 9,  1, 1);
        add(0, 0, 9,  1, 0, 0, 2, 9,  1, 1);
        add(0, 0, 15, 1, 0, 0, 2, 9,  1, 1);
        add(0, 0, 6,  1, 0, 0, 2, 9,  1, 1);
        add(0, 1, 9,  1, 0, 0, 3, 6,  1, 1);
        add(0, 1, 6,  1, 0, 0, 4, 12, 1, 1);
        add(0, 1, 12, 1, 0, 0, 5, 2,  1, 1);
        add(0, 1, 2,  1, 0, 0, 6, 8,  1, 1);
        add(0, 1, 8,  1, 0, 1, 7, 7,  1, 2);
        add(0, 0, 7,  1, 0, 0, 7, 7,  1, 2);
        add(0, 1, 15, 0, 1, 0, 0, 0,  2, 2);
        add(0, 0, 13, 0, 0, 0, 0, 0,  2, 2);
        add(0, 1, 15, 0, 0, 0, 0, 0,  2, 2);
        add(0, 1, 7,  0, 0, 0, 0, 0,  2, 2);
        add(0, 1, 13, 0, 0, 0, 1, 7,  2, 2);
        add(0, 1, 7,  0, 0, 0, 2, 9,  2, 2);
        add(0, 1, 4,  0, 0, 0, 0, 0,  2, 2);
        add(0, 1, 13, 0, 0, 0, 1, 7,  2, 2);
        add(0, 1, 7,  0, 0, 0, 2, 9,  2, 2);
        add(0, 1, 9,  0, 0, 0, 3, 6,  2, 2);
        add(0, 1, 6,  1, 0, 0, 4, 12, 2, 2);
        add(0, 1, 0,  0, 1, 0, 0, 0,  3, 2);
        add(0, 1, 12, 0, 0, 0, 5, 2,  3, 2);
        add(0, 1, 2,  0, 0, 0, 6, 8,  3, 2);
        add(0, 1, 8,  0, 0, 0, 7, 7,  3, 2);
        add(0, 1, 7,  1, 0, 0, 0, 13, 3, 2);
        // reset while locked, then reset overriding en=0
        add(1, 1, 13, 0, 0, 0, 0, 0,  0, 0);
        add(1, 0, 9,  0, 0, 0, 0, 0,  0, 0);
        add(0, 1, 13, 0, 0, 0, 1, 7,  0, 0);
        add(0, 1, 0,  0, 0, 0, 0, 0,  0, 0);
        // five lock/mismatch rounds: the narrow instance saturates at 3
        for (int k = 0; k < 5; k++) begin
            add(0, 1, 13, 0, 0, 0, 1, 7,  k, 0);
            add(0, 1, 7,  0, 0, 0, 2, 9,  k, 0);
            add(0, 1, 9,  0, 0, 0, 3, 6,  k, 0);
            add(0, 1, 6,  1, 0, 0, 4, 12, k, 0);
            add(0, 1, 5,  0, 1, 0, 0, 0,  k + 1, 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge C);
            R  = vecs[i].r;
            en = vecs[i].e;
            Q  = vecs[i].q;
            sbq.push_back(vecs[i]);
            @(posedge C);
            #1;
            v = sbq.pop_front();
            check("locked", i, int'(locked), int'(v.lk));
            check("err", i, int'(err), int'(v.er));
            check("period_done", i, int'(period_done), int'(v.pd));
            check("pos", i, int'(pos), int'(v.pos));
            check("expected", i, int'(expected), int'(v.ex));
            check("err_count", i, int'(err_count), v.ec);
            check("period_count", i, int'(period_count), v.pc);
            check("sat_err_count", i, int'(err_count2), (v.ec > 3) ? 3 : v.ec);
            check("sat_err", i, int'(err2), int'(v.er));
        end
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_checker.md
Name: seq_checker

Overview:
- Sequence checker that sits directly downstream of the arbitrary JK counter and consumes its 4-bit output Q.
- The counter must produce the 8-step cycle 7,13,7,9,6,12,2,8 (index 0..7).
- The checker acquires phase on this cycle, confirms lock after a run of consecutive matches, then flags every deviation and counts completed periods.
- It is the self-check stage used by the counter bench and by any on-board monitor.

Parameters:
- LOCK_COUNT, 3: consecutive matching samples required in ACQUIRE before locked asserts (legal 1..7).
- ERR_W, 8: width of err_count and period_count.

Ports:
- C  input  1  clock; every register updates on the rising edge of C (the counter changes on the falling edge, so Q is stable here).
- R  input  1  reset; synchronous and active-high.
- en  input  1  sample enable; when low, all state holds.
- Q  input  4  counter output under test.
- locked  output  1  high while in LOCKED.
- err  output  1  one-cycle pulse on a mismatch detected in LOCKED.
- err_count  output  ERR_W  LOCKED mismatches; saturates at all-ones.
- period_count  output  ERR_W  completed full periods seen in LOCKED; wraps.
- period_done  output  1  one-cycle pulse when the index-7 value (8) matches in LOCKED.
- pos  output  3  index of the last accepted sample; 0 in SEARCH.
- expected  output  4  value expected at the next sample, i.e. seq[(pos+1) mod 8]; 0 in SEARCH.

Behaviour:
- Sequence table (ROM): idx0=7, 1=13, 2=7, 3=9, 4=6, 5=12, 6=2, 7=8.
  - Unique values map to an index: 13→1, 9→3, 6→4, 12→5, 2→6, 8→7.
  - 7 is ambiguous (idx 0 or 2).
  - 0,1,3,4,5,10,11,14,15 are illegal.
- Reset:
  - R high at a rising edge forces state=SEARCH.
  - All outputs go to 0, internal match counter to 0.
  - R overrides en and any in-flight state, including mid-period.
- en low: no state, counter or output-register change; err and period_done are 0 that cycle.
- State machine, 3 states, evaluated per sample (rising edge with en=1, R=0):
  - SEARCH:
    - Unique value v → go to ACQUIRE, pos=idx(v), match counter=0.
    - 7 or an illegal value → stay in SEARCH; no err.
  - ACQUIRE:
    - Q==expected → pos=pos+1 mod 8, match counter+1.
    - If the incremented count equals LOCK_COUNT → go to LOCKED; locked is high from that edge.
    - Mismatch → SEARCH, pos=0, counter cleared, no err, err_count unchanged.
  - LOCKED:
    - Q==expected → pos=pos+1 mod 8.
    - If the accepted index is 7 → period_done=1 for one cycle, period_count+1 (wraps at 2^ERR_W).
    - Mismatch → err=1 for one cycle, err_count+1 unless saturated, locked drops that edge, state=SEARCH, pos=0.
    - The mismatching sample is not reused for reacquisition.
- Latency: all outputs are registered; a sample at edge k is reflected on outputs immediately after edge k.
- Simultaneous events: a mismatch and a period completion cannot coincide, because period_done requires a match.
- The counter's 15→7 substitution is done upstream; 15 arriving here is illegal and is handled as a mismatch (LOCKED) or ignored (SEARCH).
- expected is combinationally derived from registered pos/state through the ROM, or registered; either way it must equal seq[(pos+1) mod 8] after each edge, and 0 in SEARCH.

Test Plan:
- Reset then clean stream 7,13,7,9,6,12,2,8,7,13… (LOCK_COUNT=3):
  - first 7 ignored; 13 acquires (pos=1, expected=7);
  - locked rises after sampling 6 (5th sample);
  - period_done pulses on each 8 thereafter; err_count stays 0.
- Locked stream, inject 5 in place of 12: err pulses one cycle, err_count=1, locked=0, pos=0; relock occurs after 2 (acquire), 8, 7, 13 (locked).
- Mismatch during ACQUIRE (13,7,4): return to SEARCH, err=0, err_count=0.
- en held low for 4 cycles mid-LOCKED with Q changing: all outputs frozen; resuming with the correct next value gives no err.
- Assert R while LOCKED with err_count=3, period_count=2: after that edge, all outputs are 0 and state is SEARCH.
- Saturation: ERR_W=2, force 5 mismatches (each relocked): err_count reads 3 and holds; err still pulses each time.
- Stream containing 15 while LOCKED: err pulses; in SEARCH, 15 is ignored.
